// File: rtl/commit_reorder_unit_pkg.sv
// commit_reorder_unit_pkg: shared commit-stage constants and the commit-slot record
package commit_reorder_unit_pkg;

    localparam int COMMIT_ID_WIDTH  = 8;
    localparam int N_INSTR_BRANCHES = 4;
    localparam int INSTR_BRANCH_MAC = 1;
    localparam int SAMPLE_WIDTH     = 16;
    localparam int CHANNEL_COUNT    = 16;
    localparam int ROB_SLOTS        = 4;
    localparam int CHANNEL_ADDR_W   = $clog2(CHANNEL_COUNT);

    // Core-default layout of one buffered result awaiting retirement
    typedef struct packed {
        logic [2*SAMPLE_WIDTH-1:0] result;
        logic [CHANNEL_ADDR_W-1:0] dest;
        logic                      acc_overwrite;
        logic                      sat_en;
        logic                      is_mac;
    } commit_slot_t;

endpackage

// File: rtl/commit_reorder_unit_sat_narrow.sv
// sat_narrow: combinational signed clamp of a 2W-bit value into W bits
module sat_narrow #(
    parameter int W = 16
) (
    input  logic [2*W-1:0] wide,
    output logic [W-1:0]   narrow
);

    logic fits;

    // The value fits when every bit above the narrow sign bit repeats the sign
    assign fits   = wide[2*W-1:W-1] == {(W+1){wide[2*W-1]}};
    assign narrow = fits ? wide[W-1:0] :
                    wide[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};

endmodule

// File: rtl/commit_reorder_unit.sv
// commit_reorder_unit: reorder window retiring branch results in commit-ID order
module commit_reorder_unit
    import commit_reorder_unit_pkg::*;
#(
    parameter int DATA_WIDTH      = SAMPLE_WIDTH,
    parameter int N_BRANCHES      = N_INSTR_BRANCHES,
    parameter int MAC_BRANCH      = INSTR_BRANCH_MAC,
    parameter int N_CHANNELS      = CHANNEL_COUNT,
    parameter int COMMIT_ID_WIDTH = commit_reorder_unit_pkg::COMMIT_ID_WIDTH,
    parameter int ROB_DEPTH       = ROB_SLOTS,
    localparam int CH_W  = $clog2(N_CHANNELS),
    localparam int IDX_W = $clog2(ROB_DEPTH),
    localparam int OCC_W = IDX_W + 1,
    localparam int RW    = 2 * DATA_WIDTH
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         enable,
    input  logic                                         flush,
    input  logic                                         sample_tick,
    input  logic [DATA_WIDTH-1:0]                        sample_in,
    input  logic [N_BRANCHES-1:0]                        in_valid,
    output logic [N_BRANCHES-1:0]                        in_ready,
    input  logic [N_BRANCHES-1:0][RW-1:0]                result,
    input  logic [N_BRANCHES-1:0][CH_W-1:0]              dest,
    input  logic [N_BRANCHES-1:0][COMMIT_ID_WIDTH-1:0]   commit_id,
    input  logic [N_BRANCHES-1:0]                        acc_overwrite,
    input  logic [N_BRANCHES-1:0]                        sat_en,
    output logic [CH_W-1:0]                              channel_write_addr,
    output logic [DATA_WIDTH-1:0]                        channel_write_val,
    output logic                                         channel_write_enable,
    output logic [RW-1:0]                                accumulator_write_val,
    output logic                                         accumulator_write_enable,
    output logic                                         accumulator_add_enable,
    output logic [COMMIT_ID_WIDTH-1:0]                   next_commit_id,
    output logic [OCC_W-1:0]                             occupancy,
    output logic                                         collision_err
);

    typedef struct packed {
        logic [RW-1:0]   result;
        logic [CH_W-1:0] dest;
        logic            acc_overwrite;
        logic            sat_en;
        logic            is_mac;
    } slot_t;

    localparam logic [COMMIT_ID_WIDTH:0] DEPTH_C = (COMMIT_ID_WIDTH + 1)'(ROB_DEPTH);

    logic [ROB_DEPTH-1:0]             slot_valid;
    slot_t                            slot_mem [ROB_DEPTH];
    logic [N_BRANCHES-1:0]            in_window;
    logic [N_BRANCHES-1:0]            accept;
    logic [N_BRANCHES-1:0][IDX_W-1:0] slot_idx;
    logic [ROB_DEPTH-1:0]             set_mask;
    logic [OCC_W-1:0]                 accept_count;
    logic                             collision;
    logic [IDX_W-1:0]                 head;
    slot_t                            head_slot;
    logic [DATA_WIDTH-1:0]            head_sat;
    logic                             retire;

    // Window test, lowest-index-wins slot arbitration and duplicate-ID detection
    always_comb begin
        in_window    = '0;
        accept       = '0;
        slot_idx     = '0;
        set_mask     = '0;
        accept_count = '0;
        collision    = 1'b0;
        for (int i = 0; i < N_BRANCHES; i++) begin
            slot_idx[i]  = commit_id[i][IDX_W-1:0];
            in_window[i] = in_valid[i] && ({1'b0, commit_id[i] - next_commit_id} < DEPTH_C);
        end
        for (int i = 0; i < N_BRANCHES; i++) begin
            accept[i] = enable && !flush && in_window[i] && !slot_valid[slot_idx[i]];
            for (int j = 0; j < i; j++) begin
                if (in_window[j] && slot_idx[j] == slot_idx[i])
                    accept[i] = 1'b0;
                if (in_window[j] && in_window[i] && commit_id[j] == commit_id[i])
                    collision = 1'b1;
            end
            if (accept[i])
                set_mask[slot_idx[i]] = 1'b1;
            accept_count = accept_count + OCC_W'(accept[i]);
        end
    end

    assign in_ready  = accept;
    assign head      = next_commit_id[IDX_W-1:0];
    assign head_slot = slot_mem[head];
    assign retire    = enable && !sample_tick && !flush && slot_valid[head];

    sat_narrow #(.W(DATA_WIDTH)) u_sat (
        .wide   (head_slot.result),
        .narrow (head_sat)
    );

    // Payload capture; contents are only meaningful while the slot valid bit is set
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_BRANCHES; i++)
            if (accept[i])
                slot_mem[slot_idx[i]] <= '{result: result[i], dest: dest[i],
                                           acc_overwrite: acc_overwrite[i],
                                           sat_en: sat_en[i], is_mac: i == MAC_BRANCH};
    end

    // Window bookkeeping, in-order retirement and one-cycle write strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_valid               <= '0;
            next_commit_id           <= '0;
            occupancy                <= '0;
            collision_err            <= 1'b0;
            channel_write_addr       <= '0;
            channel_write_val        <= '0;
            channel_write_enable     <= 1'b0;
            accumulator_write_val    <= '0;
            accumulator_write_enable <= 1'b0;
            accumulator_add_enable   <= 1'b0;
        end else begin
            channel_write_enable     <= 1'b0;
            accumulator_write_enable <= 1'b0;
            accumulator_add_enable   <= 1'b0;
            if (flush) begin
                slot_valid     <= '0;
                next_commit_id <= '0;
                occupancy      <= '0;
            end else if (enable) begin
                slot_valid <= slot_valid | set_mask;
                if (retire)
                    slot_valid[head] <= 1'b0;
                next_commit_id <= next_commit_id + COMMIT_ID_WIDTH'(retire);
                occupancy      <= occupancy + accept_count - OCC_W'(retire);
                collision_err  <= collision_err | collision;
                if (sample_tick) begin
                    channel_write_addr   <= '0;
                    channel_write_val    <= sample_in;
                    channel_write_enable <= 1'b1;
                end else if (retire && head_slot.is_mac) begin
                    accumulator_write_val    <= head_slot.result;
                    accumulator_write_enable <= 1'b1;
                    accumulator_add_enable   <= !head_slot.acc_overwrite;
                end else if (retire) begin
                    channel_write_addr   <= head_slot.dest;
                    channel_write_val    <= head_slot.sat_en ? head_sat : head_slot.result[DATA_WIDTH-1:0];
                    channel_write_enable <= 1'b1;
                end
            end
        end
    end

endmodule
